// File: rtl/sos_cascade_tdm.sv
// Time-multiplexed cascade of N_SEC Direct Form I biquads sharing one MAC.
// Each section output is rounded and saturated before feeding the next.
module sos_cascade_tdm #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int N_SEC  = 3,
  parameter int ACC_W  = 40
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [3:0]        coef_sec,
  input  logic [2:0]        coef_sel,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  input  logic              clear_state
);

  localparam int SW = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam logic [SW-1:0] LAST_SEC = SW'(N_SEC - 1);
  localparam logic [4:0] N_SEC_W = 5'(N_SEC);
  localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state;
  logic [SW-1:0]             sec;
  logic [2:0]                tap;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  cur_x;

  // Feedback taps (a1, a2) are stored already negated, so every tap adds.
  logic signed [COEF_W-1:0]  coef [N_SEC][5];
  logic signed [DATA_W-1:0]  x1 [N_SEC];
  logic signed [DATA_W-1:0]  x2 [N_SEC];
  logic signed [DATA_W-1:0]  y1 [N_SEC];
  logic signed [DATA_W-1:0]  y2 [N_SEC];

  logic signed [COEF_W-1:0]  c_sel;
  logic signed [DATA_W-1:0]  d_sel;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [DATA_W-1:0]  y_sat;
  logic                      addr_ok;
  logic                      wr_ok;
  logic                      accept;

  always_comb begin
    c_sel = coef[sec][tap];
    case (tap)
      3'd0:    d_sel = cur_x;
      3'd1:    d_sel = x1[sec];
      3'd2:    d_sel = x2[sec];
      3'd3:    d_sel = y1[sec];
      default: d_sel = y2[sec];
    endcase
    prod    = c_sel * d_sel;
    acc_sum = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    rounded = (acc_sum + RND) >>> FRAC;
    if (rounded > Y_MAX)
      y_sat = Y_MAX[DATA_W-1:0];
    else if (rounded < Y_MIN)
      y_sat = Y_MIN[DATA_W-1:0];
    else
      y_sat = rounded[DATA_W-1:0];
    addr_ok = ({1'b0, coef_sec} < N_SEC_W) && (coef_sel <= 3'd4);
    wr_ok   = coef_we && addr_ok && (state != MAC);
    accept  = in_valid && (state != MAC);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      coef_err  <= 1'b0;
      sec       <= '0;
      tap       <= '0;
      acc       <= '0;
      cur_x     <= '0;
      for (int s = 0; s < N_SEC; s++) begin
        x1[s]      <= '0;
        x2[s]      <= '0;
        y1[s]      <= '0;
        y2[s]      <= '0;
        coef[s][0] <= B0_ONE;
        for (int t = 1; t < 5; t++) coef[s][t] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= coef_we && !wr_ok;
      if (wr_ok) coef[coef_sec[SW-1:0]][coef_sel] <= coef_data;

      case (state)
        IDLE: begin
          if (clear_state) begin
            for (int s = 0; s < N_SEC; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end
        end
        MAC: begin
          if (tap == 3'd4) begin
            x2[sec] <= x1[sec];
            x1[sec] <= cur_x;
            y2[sec] <= y1[sec];
            y1[sec] <= y_sat;
            cur_x   <= y_sat;
            acc     <= '0;
            tap     <= '0;
            if (sec == LAST_SEC) begin
              state     <= DONE;
              out_data  <= y_sat;
              out_valid <= 1'b1;
              in_ready  <= 1'b1;
            end else begin
              sec <= sec + 1'b1;
            end
          end else begin
            acc <= acc_sum;
            tap <= tap + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A new sample is taken from IDLE or back-to-back from DONE.
      if (accept) begin
        cur_x    <= in_data;
        sec      <= '0;
        tap      <= '0;
        acc      <= '0;
        state    <= MAC;
        in_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sos_cascade_tdm.sv
// Bench for sos_cascade_tdm: directed and random samples checked against a
// plain-arithmetic cascade model.
module tb_sos_cascade_tdm;
  localparam int N   = 3;
  localparam int LAT = 5 * N;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        coef_we;
  logic [3:0]  coef_sec;
  logic [2:0]  coef_sel;
  logic [15:0] coef_data;
  logic        coef_err;
  logic        clear_state;

  int n_tests = 0;
  int n_fail  = 0;

  int mc [N][5];
  int mx1 [N];
  int mx2 [N];
  int my1 [N];
  int my2 [N];

  sos_cascade_tdm #(.DATA_W(16), .COEF_W(16), .FRAC(14), .N_SEC(N), .ACC_W(40)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .coef_we(coef_we), .coef_sec(coef_sec),
    .coef_sel(coef_sel), .coef_data(coef_data), .coef_err(coef_err), .clear_state(clear_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mc[k][0] = 16384;
      for (int t = 1; t < 5; t++) mc[k][t] = 0;
    end
    model_clear();
  endtask

  task automatic model_step(input int x, output int y);
    longint s;
    longint r;
    int v;
    v = x;
    for (int k = 0; k < N; k++) begin
      s = longint'(mc[k][0]) * v + longint'(mc[k][1]) * mx1[k] + longint'(mc[k][2]) * mx2[k]
        + longint'(mc[k][3]) * my1[k] + longint'(mc[k][4]) * my2[k];
      r = (s + 64'sd8192) >>> 14;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      mx2[k] = mx1[k]; mx1[k] = v;
      my2[k] = my1[k]; my1[k] = int'(r);
      v = int'(r);
    end
    y = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_sample(input int x, input bit clr);
    if (clr) step();
    chk("in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = 16'(x);
    clear_state = clr;
    step();
    in_valid = 1'b0;
    clear_state = 1'b0;
  endtask

  task automatic wait_out(input int elapsed, output int y);
    int c;
    c = elapsed;
    while (out_valid !== 1'b1 && c < LAT + 10) begin
      step();
      c++;
    end
    chk("latency", c, LAT);
    chk("out_valid", out_valid, 1);
    y = $signed(out_data);
  endtask

  task automatic sample_chk(input int x, input string tag, output int y);
    int e;
    model_step(x, e);
    begin_sample(x, 1'b0);
    wait_out(0, y);
    chk(tag, y, e);
    $display("[TB] %s in=%0d out=%0d model=%0d", tag, x, y, e);
  endtask

  task automatic write_coef(input int s, input int sel, input int val, input bit exp_err);
    coef_we = 1'b1;
    coef_sec = 4'(s);
    coef_sel = 3'(sel);
    coef_data = 16'(val);
    step();
    coef_we = 1'b0;
    chk("coef_err", coef_err, exp_err);
    if (!exp_err) mc[s][sel] = val;
    $display("[TB] coef write sec=%0d sel=%0d val=%0d err=%0b", s, sel, val, coef_err);
  endtask

  task automatic idle_clear();
    step();
    clear_state = 1'b1;
    step();
    clear_state = 1'b0;
    model_clear();
  endtask

  task automatic load_impulse_coefs();
    write_coef(0, 0, 98, 1'b0);
    write_coef(0, 1, 51, 1'b0);
    write_coef(0, 2, 98, 1'b0);
    write_coef(0, 3, 7845, 1'b0);
    write_coef(0, 4, 0, 1'b0);
  endtask

  initial begin
    int y;
    int e;
    int imp_exp [3];
    imp_exp = '{98, 98, 145};
    RST = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_sec = '0; coef_sel = '0; coef_data = '0; clear_state = 1'b0;
    model_reset();
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_coef_err", coef_err, 0);
    RST = 1'b0;
    step();

    // Passthrough straight after reset
    sample_chk(1000, "pass", y);
    chk("pass_const", y, 1000);
    sample_chk(-1234, "pass", y);
    chk("pass_const", y, -1234);

    // Impulse response, back-to-back, zero history via clear_state
    load_impulse_coefs();
    idle_clear();
    for (int i = 0; i < 120; i++) begin
      sample_chk((i == 0) ? 16384 : 0, "impulse", y);
      if (i < 3) chk("impulse_const", y, imp_exp[i]);
    end

    // Saturation
    write_coef(0, 0, 32767, 1'b0);
    for (int t = 1; t < 5; t++) write_coef(0, t, 0, 1'b0);
    sample_chk(30000, "sat_pos", y);
    chk("sat_pos_const", y, 32767);
    sample_chk(-30000, "sat_neg", y);
    chk("sat_neg_const", y, -32768);

    // Rejected writes: during MAC and to bad addresses
    write_coef(0, 0, 16384, 1'b0);
    model_step(500, e);
    begin_sample(500, 1'b0);
    coef_we = 1'b1; coef_sec = 4'd0; coef_sel = 3'd0; coef_data = 16'd0;
    step();
    coef_we = 1'b0;
    chk("mac_write_err", coef_err, 1);
    wait_out(1, y);
    chk("mac_write_out", y, e);
    chk("mac_write_const", y, 500);
    $display("[TB] mac write rejected, out=%0d", y);
    sample_chk(700, "after_rej", y);
    chk("after_rej_const", y, 700);
    write_coef(3, 0, 0, 1'b1);
    write_coef($urandom_range(0, 2), 5, 0, 1'b1);
    write_coef(0, 7, 0, 1'b1);
    sample_chk(-77, "after_bad_addr", y);
    chk("after_bad_addr_const", y, -77);

    // Reset in the middle of a sample
    load_impulse_coefs();
    sample_chk(16384, "pre_rst", y);
    sample_chk(0, "pre_rst", y);
    sample_chk(300, "pre_rst", y);
    begin_sample(1234, 1'b0);
    step(); step(); step();
    RST = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", $signed(out_data), 0);
    $display("[TB] mid-sample reset out_valid=%0b in_ready=%0b out_data=%0d", out_valid, in_ready, $signed(out_data));
    step(); step();
    RST = 1'b0;
    model_reset();
    step();
    sample_chk(16384, "post_rst", y);
    chk("post_rst_const", y, 16384);
    sample_chk(0, "post_rst", y);
    chk("post_rst_const", y, 0);
    sample_chk(0, "post_rst", y);
    load_impulse_coefs();
    for (int i = 0; i < 3; i++) begin
      sample_chk((i == 0) ? 16384 : 0, "post_rst_imp", y);
      chk("post_rst_imp_const", y, imp_exp[i]);
    end

    // clear_state during MAC is ignored
    model_step(0, e);
    begin_sample(0, 1'b0);
    step();
    clear_state = 1'b1;
    step();
    clear_state = 1'b0;
    wait_out(2, y);
    chk("clear_in_mac", y, e);
    $display("[TB] clear in MAC out=%0d model=%0d", y, e);

    // clear_state together with accept
    model_clear();
    model_step(5000, e);
    begin_sample(5000, 1'b1);
    wait_out(0, y);
    chk("clear_accept", y, e);
    chk("clear_accept_const", y, 30);
    $display("[TB] clear+accept out=%0d model=%0d", y, e);

    // clear_state in IDLE after nonzero history
    sample_chk(-4000, "hist", y);
    idle_clear();
    sample_chk(5000, "clear_idle", y);
    chk("clear_idle_const", y, 30);

    // Random coefficients and samples
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        write_coef($urandom_range(0, N - 1), $urandom_range(0, 4),
                   int'($urandom_range(0, 40000)) - 20000, 1'b0);
      if (it % 10 == 9) idle_clear();
      sample_chk(int'($urandom_range(0, 65535)) - 32768, "random", y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
